// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and the round-robin winner search for the four-requester arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [IDX_W-1:0] req_idx_t;

  // Scan last_idx+1 .. last_idx+4 (mod 4); the previous owner is checked last.
  function automatic req_idx_t next_rr_winner(input logic [N_REQ-1:0] req,
                                              input req_idx_t last_idx);
    req_idx_t winner;
    req_idx_t cand;
    logic     found;
    winner = last_idx;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_idx + req_idx_t'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting engines (master) and the arbiter (slave).
interface rr_arbiter_4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  req_idx_t         gnt_idx;
  logic             gnt_valid;
  logic             expired;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input expired);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output expired);

endinterface

// File: rtl/rr_arbiter_4_decoder_2_4.sv
// 2-to-4 binary to one-hot decoder driving the shared resource select lines.
module decoder_2_4 (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign onehot[gi] = (sel == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with one dead cycle between owners.
// Optional per-ownership hold limit enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4_if.slave  bus
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_range
    $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
  end

  arb_state_t       state_reg;
  req_idx_t         idx_reg;
  req_idx_t         last_idx_reg;
  logic             valid_reg;
  logic [N_REQ-1:0] dec_onehot;
  logic [N_REQ-1:0] gnt_mask;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_reg;
  logic       expired_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      last_idx_reg <= 2'b11;
      valid_reg    <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_reg <= '0;
      expired_reg  <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      expired_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            idx_reg   <= next_rr_winner(bus.req, last_idx_reg);
            valid_reg <= 1'b1;
            state_reg <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
          end
        end
        GRANT: begin
          // A voluntary release wins over the hold limit on the same cycle.
          if (!bus.req[idx_reg]) begin
            state_reg    <= IDLE;
            valid_reg    <= 1'b0;
            last_idx_reg <= idx_reg;
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg    <= IDLE;
            valid_reg    <= 1'b0;
            last_idx_reg <= idx_reg;
            expired_reg  <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  decoder_2_4 u_dec (
    .sel    (idx_reg),
    .onehot (dec_onehot)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt_mask[gi] = dec_onehot[gi] & valid_reg;
    end
  endgenerate

  assign bus.gnt       = gnt_mask;
  assign bus.gnt_idx   = idx_reg;
  assign bus.gnt_valid = valid_reg;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.expired   = expired_reg;
`else
  assign bus.expired   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed stimulus with a grant scoreboard: each expected ownership is queued, the monitor checks it when it ends.
module tb_rr_arbiter_4;
  import rr_arb_pkg::*;

  typedef struct {
    int idx;
    int start;
    int len;
    int exp;
  } grant_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  grant_t sb[$];

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int idx, input int start, input int len, input int exp);
    grant_t g;
    g.idx = idx; g.start = start; g.len = len; g.exp = exp;
    sb.push_back(g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Monitor: measure each ownership and compare against the scoreboard when it ends.
  initial begin : monitor
    logic       prev_valid;
    int         cur_idx, cur_start, cur_len;
    logic [3:0] cur_gnt;
    logic [3:0] want_gnt;
    bit         stable;
    grant_t     g;
    prev_valid = 1'b0;
    cur_idx = 0; cur_start = 0; cur_len = 0; cur_gnt = '0; stable = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.gnt_valid && !prev_valid) begin
        cur_idx = int'(bus.gnt_idx); cur_gnt = bus.gnt;
        cur_start = cyc; cur_len = 1; stable = 1'b1;
      end else if (bus.gnt_valid && prev_valid) begin
        cur_len = cur_len + 1;
        if (int'(bus.gnt_idx) != cur_idx || bus.gnt != cur_gnt) stable = 1'b0;
      end else if (!bus.gnt_valid && prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant_idx", cur_idx, -1);
        end else begin
          g = sb.pop_front();
          want_gnt = 4'b0001 << g.idx;
          $display("grant idx=%0d start=%0d len=%0d expired=%0d", cur_idx, cur_start, cur_len, bus.expired);
          chk("gnt_idx", cur_idx, g.idx);
          chk("gnt_onehot", int'(cur_gnt), int'(want_gnt));
          chk("grant_start_cycle", cur_start, g.start);
          chk("grant_length", cur_len, g.len);
          chk("expired_at_release", int'(bus.expired), g.exp);
          chk("grant_stable", int'(stable), 1);
        end
      end else if (bus.expired) begin
        chk("expired_spurious", 1, 0);
      end
      prev_valid = bus.gnt_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int s, t, r;
    logic [3:0] one;
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_gnt_idx", int'(bus.gnt_idx), 0);
    chk("reset_gnt_valid", int'(bus.gnt_valid), 0);
    chk("reset_expired", int'(bus.expired), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single requester 2, held 3 cycles.
    s = cyc; bus.req = 4'b0100;
    push(2, s + 1, 3, 0);
    wait_to(s + 3); bus.req = 4'b0000;
    step(); step();

    // Request withdrawn before the next edge samples it: never granted.
    bus.req = 4'b0001; #3 bus.req = 4'b0000;
    step(); step();

    // All four requesting, each owner drops for one cycle: order 0,1,2,3,0.
    do_reset();
    s = cyc; bus.req = 4'b1111; t = s + 1;
    for (int k = 0; k < 5; k++) begin
      push(k % 4, t, 3, 0);
      wait_to(t + 2);
      one = 4'b0001 << (k % 4);
      bus.req = 4'b1111 & ~one;
      wait_to(t + 3);
      bus.req = (k == 4) ? 4'b0000 : 4'b1111;
      t = t + 4;
    end
    step(); step();

    // Owner 1 releases with 3 and 0 pending: 3 wins, then 0.
    step();
    s = cyc; bus.req = 4'b0010;
    push(1, s + 1, 2, 0);
    wait_to(s + 1); bus.req = 4'b1011;
    wait_to(s + 2); bus.req = 4'b1001;
    push(3, s + 4, 2, 0);
    wait_to(s + 5); bus.req = 4'b0001;
    push(0, s + 7, 1, 0);
    wait_to(s + 7); bus.req = 4'b0000;
    step(); step();

    // Asynchronous reset in the middle of a grant to 1.
    step();
    s = cyc; bus.req = 4'b0010;
    push(1, s + 1, 1, 0);
    wait_to(s + 2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_gnt", int'(bus.gnt), 0);
    chk("async_reset_gnt_valid", int'(bus.gnt_valid), 0);
    bus.req = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(1, r + 1, 2, 0);
    wait_to(r + 2); bus.req = 4'b0000;
    step(); step();

`ifdef RR_ARB_TIMEOUT_EN
    // Two requesters held: each evicted after 8 cycles, alternating.
    do_reset();
    s = cyc; bus.req = 4'b0011;
    push(0, s + 1, 8, 1);
    push(1, s + 10, 8, 1);
    push(0, s + 19, 1, 0);
    wait_to(s + 19); bus.req = 4'b0000;
    step(); step();

    // Release sampled on the limit cycle: normal release, no expired pulse.
    step();
    s = cyc; bus.req = 4'b0100;
    push(2, s + 1, 8, 0);
    wait_to(s + 8); bus.req = 4'b0000;
    step(); step();
`endif

    step(); step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
